// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Used by the storage/scoreboard top and its read-port slices.
package regfile_pkg;

  localparam int DEF_DW   = 32;
  localparam int DEF_NREG = 32;
  localparam int ZERO_IDX = 0;

  function automatic int slice_lo(
    input int k,
    input int w
  );
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard_read_port.sv
// One read port: address mux, r0 masking, write bypass, busy lookup.
// Bypass never forwards into the hardwired-zero register.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int NREG     = DEF_NREG,
  parameter int AW       = $clog2(NREG),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [NREG*DW-1:0] regs,
  input  logic [NREG-1:0]    busy,
  input  logic [AW-1:0]      rd_addr,
  input  logic               fwd_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  output logic [DW-1:0]      rd_data,
  output logic               rd_busy
);

  logic          zero_hit;
  logic          fwd;
  logic [DW-1:0] stored;

  assign zero_hit = (ZERO_REG != 0) &&
                    (rd_addr == AW'(ZERO_IDX));
  assign fwd = (BYPASS != 0) && fwd_en &&
               (wr_addr == rd_addr) && !zero_hit;
  assign stored =
    regs[slice_lo(int'(rd_addr), DW) +: DW];

  always_comb begin
    rd_data = stored;
    rd_busy = busy[rd_addr];
    if (zero_hit) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end else if (fwd) begin
      rd_data = wr_data;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Parametrised multi-read register file with per-register busy
// scoreboard; decode reads/issues, writeback writes and clears.
module regfile_mp_scoreboard
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int NREG     = DEF_NREG,
  parameter int AW       = $clog2(NREG),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 clear_neg,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_addr,
  output logic [NREG-1:0]      busy_vec
);

  logic [NREG*DW-1:0] regs;
  logic [NREG-1:0]    busy;
  logic               wr_ok;
  logic               iss_ok;
  logic               fwd_en;

  assign wr_ok = wr_en &&
    !((ZERO_REG != 0) && (wr_addr == AW'(ZERO_IDX)));
  assign iss_ok = issue_en &&
    !((ZERO_REG != 0) && (issue_addr == AW'(ZERO_IDX)));

  // Keep outputs at zero while held in reset, even with wr_en high.
  assign fwd_en = wr_en && clear_neg;

  always_ff @(posedge clk or negedge clear_neg) begin
    if (!clear_neg) begin
      regs <= '0;
    end else if (wr_ok) begin
      regs[slice_lo(int'(wr_addr), DW) +: DW] <= wr_data;
    end
  end

  // Issue is applied last so a same-cycle new producer wins.
  always_ff @(posedge clk or negedge clear_neg) begin
    if (!clear_neg) begin
      busy <= '0;
    end else begin
      if (wr_en) busy[wr_addr] <= 1'b0;
      if (iss_ok) busy[issue_addr] <= 1'b1;
    end
  end

  assign busy_vec = busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DW       (DW),
      .NREG     (NREG),
      .AW       (AW),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .regs    (regs),
      .busy    (busy),
      .rd_addr (rd_addr[slice_lo(k, AW) +: AW]),
      .fwd_en  (fwd_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[slice_lo(k, DW) +: DW]),
      .rd_busy (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Scoreboard bench: bypass / no-bypass 32x32 pair plus a 16b x8 x4-port
// instance checked against a reference model.
module tb_regfile_mp_scoreboard;

  logic clk = 1'b0;
  logic clear_neg = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [63:0] rd_data0, rd_data1;
  logic [1:0]  rd_busy0, rd_busy1;
  logic [31:0] bv0, bv1;

  logic [11:0] rd_addr2;
  logic        wr_en2;
  logic [2:0]  wr_addr2;
  logic [15:0] wr_data2;
  logic        issue_en2;
  logic [2:0]  issue_addr2;
  logic [63:0] rd_data2;
  logic [3:0]  rd_busy2;
  logic [7:0]  bv2;

  regfile_mp_scoreboard #(.BYPASS(1)) u_byp (
    .clk(clk), .clear_neg(clear_neg),
    .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_busy(rd_busy0), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .busy_vec(bv0)
  );

  regfile_mp_scoreboard #(.BYPASS(0)) u_nobyp (
    .clk(clk), .clear_neg(clear_neg),
    .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_busy(rd_busy1), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .busy_vec(bv1)
  );

  regfile_mp_scoreboard #(
    .DW(16), .NREG(8), .NUM_RD(4)
  ) u_small (
    .clk(clk), .clear_neg(clear_neg),
    .rd_addr(rd_addr2), .rd_data(rd_data2),
    .rd_busy(rd_busy2), .wr_en(wr_en2),
    .wr_addr(wr_addr2), .wr_data(wr_data2),
    .issue_en(issue_en2), .issue_addr(issue_addr2),
    .busy_vec(bv2)
  );

  typedef struct {
    string       nm;
    int          dut;
    int          port;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] actual(exp_t e);
    logic [31:0] r;
    r = '0;
    case (e.dut)
      0: case (e.kind)
        0: r = rd_data0[e.port*32 +: 32];
        1: r = 32'(rd_busy0[e.port]);
        default: r = bv0;
      endcase
      1: case (e.kind)
        0: r = rd_data1[e.port*32 +: 32];
        1: r = 32'(rd_busy1[e.port]);
        default: r = bv1;
      endcase
      default: case (e.kind)
        0: r = 32'(rd_data2[e.port*16 +: 16]);
        1: r = 32'(rd_busy2[e.port]);
        default: r = 32'(bv2);
      endcase
    endcase
    return r;
  endfunction

  always begin
    @(sample_ev);
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e);
      n_cmp++;
      if (a !== e.exp) begin
        n_bad++;
        $display("FAIL %s dut%0d p%0d: got %h want %h",
                 e.nm, e.dut, e.port, a, e.exp);
      end
    end
  end

  task automatic exp_port(input int dut, input int port,
                          input logic [31:0] d, input logic b,
                          input string nm);
    exp_t e;
    e.nm = nm; e.dut = dut; e.port = port;
    e.kind = 0; e.exp = d;
    q.push_back(e);
    e.nm = {nm, "_busy"}; e.kind = 1; e.exp = 32'(b);
    q.push_back(e);
  endtask

  task automatic exp_vec(input int dut, input logic [31:0] v,
                         input string nm);
    exp_t e;
    e.nm = nm; e.dut = dut; e.port = 0;
    e.kind = 2; e.exp = v;
    q.push_back(e);
  endtask

  task automatic both(input int port,
                      input logic [31:0] d0, input logic b0,
                      input logic [31:0] d1, input logic b1,
                      input string nm);
    exp_port(0, port, d0, b0, nm);
    exp_port(1, port, d1, b1, nm);
  endtask

  task automatic vec01(input logic [31:0] v, input string nm);
    exp_vec(0, v, nm);
    exp_vec(1, v, nm);
  endtask

  task automatic probe();
    #1;
    ->sample_ev;
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = 5'(a);
    wr_data = d;
  endtask

  logic [15:0] m_mem [8];
  logic [7:0]  m_busy;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    issue_en = 0; issue_addr = '0;
    rd_addr2 = '0; wr_en2 = 0; wr_addr2 = '0; wr_data2 = '0;
    issue_en2 = 0; issue_addr2 = '0;
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_busy = '0;

    repeat (2) @(negedge clk);
    for (int p = 0; p < 2; p++) both(p, 0, 0, 0, 0, "rst");
    vec01(0, "rst_vec");
    for (int p = 0; p < 4; p++) exp_port(2, p, 0, 0, "rst2");
    exp_vec(2, 0, "rst2_vec");
    probe();
    clear_neg = 1'b1;

    @(negedge clk); wr(3, 32'hFFFF0000); set_rd(2, 3);
    @(negedge clk); wr_en = 0;
    both(1, 32'hFFFF0000, 0, 32'hFFFF0000, 0, "t1_pre");
    probe();
    wr(3, 32'h1); issue_en = 1; issue_addr = 5'd4;
    clear_neg = 1'b0;
    both(1, 0, 0, 0, 0, "t1_async");
    vec01(0, "t1_async_vec");
    probe();
    n_cmp++;
    if (rd_data0[63:32] !== 32'h0) begin
      n_bad++;
      $display("FAIL t1_direct: got %h", rd_data0[63:32]);
    end
    @(negedge clk);
    clear_neg = 1'b1; wr_en = 0; issue_en = 0;
    both(1, 0, 0, 0, 0, "t1_after");
    vec01(0, "t1_after_vec");
    probe();

    @(negedge clk); wr(3, 32'hFFFF0000); set_rd(3, 2);
    both(0, 32'hFFFF0000, 0, 0, 0, "t2_w3");
    probe();
    @(negedge clk); wr(2, 32'hFFFFFFFF);
    both(0, 32'hFFFF0000, 0, 32'hFFFF0000, 0, "t2_r3");
    both(1, 32'hFFFFFFFF, 0, 0, 0, "t2_w2");
    probe();
    @(negedge clk); wr(0, 32'h12345678); set_rd(0, 2);
    both(0, 0, 0, 0, 0, "t2_w0");
    both(1, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, "t2_r2");
    probe();
    @(negedge clk); wr_en = 0; set_rd(0, 3);
    both(0, 0, 0, 0, 0, "t2_r0");
    both(1, 32'hFFFF0000, 0, 32'hFFFF0000, 0, "t2_r3b");
    probe();

    @(negedge clk); wr(5, 32'hA5A5A5A5); set_rd(5, 5);
    for (int p = 0; p < 2; p++)
      both(p, 32'hA5A5A5A5, 0, 0, 0, "t3_same");
    probe();
    @(negedge clk); wr_en = 0;
    for (int p = 0; p < 2; p++)
      both(p, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, "t3_next");
    probe();

    @(negedge clk); issue_en = 1; issue_addr = 5'd7; set_rd(7, 7);
    both(0, 0, 0, 0, 0, "t4_iss");
    vec01(0, "t4_iss_vec");
    probe();
    @(negedge clk); issue_en = 0;
    for (int p = 0; p < 2; p++) both(p, 0, 1, 0, 1, "t4_busy");
    vec01(32'h80, "t4_busy_vec");
    probe();
    n_cmp++;
    if (bv0[7] !== 1'b1) begin
      n_bad++;
      $display("FAIL t4_direct: busy_vec %h", bv0);
    end
    @(negedge clk); wr(7, 32'h11);
    both(0, 32'h11, 0, 0, 1, "t4_wr");
    vec01(32'h80, "t4_wr_vec");
    probe();
    n_cmp++;
    if (rd_busy0[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL t4_wr_direct: rd_busy %b", rd_busy0);
    end
    @(negedge clk); wr_en = 0;
    both(0, 32'h11, 0, 32'h11, 0, "t4_clr");
    vec01(0, "t4_clr_vec");
    probe();

    @(negedge clk);
    wr(9, 32'hCAFE0009); issue_en = 1; issue_addr = 5'd9;
    set_rd(9, 9);
    both(1, 32'hCAFE0009, 0, 0, 0, "t5_same");
    probe();
    @(negedge clk); wr_en = 0; issue_addr = 5'd0;
    both(1, 32'hCAFE0009, 1, 32'hCAFE0009, 1, "t5_busy");
    vec01(32'h200, "t5_vec");
    probe();
    n_cmp++;
    if (bv1 !== 32'h200) begin
      n_bad++;
      $display("FAIL t5_direct: busy_vec %h", bv1);
    end
    @(negedge clk); issue_en = 0; set_rd(0, 9);
    both(0, 0, 0, 0, 0, "t5_r0");
    vec01(32'h200, "t5_r0_vec");
    probe();

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      wr_en2 = 1'($urandom_range(0, 1));
      wr_addr2 = 3'($urandom_range(0, 7));
      wr_data2 = 16'($urandom);
      issue_en2 = 1'($urandom_range(0, 1));
      issue_addr2 = 3'($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) begin
        logic [2:0]  a;
        logic [15:0] d;
        logic        b;
        logic        fw;
        a = 3'((i + 3 * k) % 8);
        rd_addr2[k*3 +: 3] = a;
        fw = wr_en2 && (wr_addr2 == a) && (a != 0);
        if (a == 0) begin
          d = '0; b = 1'b0;
        end else if (fw) begin
          d = wr_data2; b = 1'b0;
        end else begin
          d = m_mem[a]; b = m_busy[a];
        end
        exp_port(2, k, 32'(d), b, "p6_port");
      end
      exp_vec(2, 32'(m_busy), "p6_vec");
      probe();
      if (wr_en2 && wr_addr2 != 0) m_mem[wr_addr2] = wr_data2;
      if (wr_en2) m_busy[wr_addr2] = 1'b0;
      if (issue_en2 && issue_addr2 != 0)
        m_busy[issue_addr2] = 1'b1;
    end

    @(negedge clk);
    if (n_cmp < 100) begin
      n_bad++;
      $display("FAIL too few comparisons: %0d", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
- Parametrised successor to the 32x32 two-read/one-write MIPS register file.
- Generalises data width, register count and number of read ports.
- Adds optional same-cycle write-to-read bypass, a hardwired-zero register 0, and a per-register busy scoreboard for the pipelined datapath.
- Sits between decode (read and issue side) and writeback (write side).

Parameters:
- DW, 32, data width in bits.
- NREG, 32, number of registers; must be a power of two, minimum 2.
- AW, $clog2(NREG), register address width; derived, do not override.
- NUM_RD, 2, number of independent read ports, 1 to 4.
- BYPASS, 1, 1 = a write in the current cycle is forwarded to a matching read port combinationally.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock.
- clear_neg  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port k uses [k*AW +: AW].
- rd_data  out  NUM_RD*DW  packed read data; port k uses [k*DW +: DW].
- rd_busy  out  NUM_RD  per-port busy flag for the addressed register.
- wr_en  in  1  writeback write enable.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- issue_en  in  1  mark the destination register busy (instruction issued).
- issue_addr  in  AW  destination register being issued.
- busy_vec  out  NREG  full scoreboard, for debug and stall logic.

Behaviour:
- Reset:
  - clear_neg low asynchronously clears all registers to 0 and all busy bits to 0, independent of clk.
  - Outputs are therefore rd_data=0, rd_busy=0, busy_vec=0 while in reset.
  - Reset deassertion takes effect from the first clk edge after release.
- Write:
  - On posedge clk with wr_en=1, reg[wr_addr] <= wr_data.
  - Suppressed when ZERO_REG=1 and wr_addr=0.
  - No gated clocks: write enable is a synchronous enable on a single clock.
- Read:
  - Combinational, zero latency.
  - rd_data[k] = reg[rd_addr[k]].
  - ZERO_REG=1 and rd_addr[k]=0 gives rd_data[k]=0.
- Bypass:
  - With BYPASS=1, a port forwards when wr_en=1, wr_addr=rd_addr[k], and the address is not zero-suppressed.
  - On forwarding, rd_data[k]=wr_data and rd_busy[k]=0.
  - With BYPASS=0, the port returns the old register value until the edge.
- Multiple ports reading the same address return identical data and flags.
- Scoreboard:
  - On posedge clk, issue_en=1 sets busy[issue_addr].
  - On posedge clk, wr_en=1 clears busy[wr_addr].
  - If both fire on the same address in the same cycle, busy ends SET: the new producer wins, the old producer's data is still written.
  - Issue to a register already busy: stays set, no error.
  - Write to a non-busy register: the data is written, busy stays 0.
  - ZERO_REG=1: busy[0] is held 0 and issue to address 0 is ignored.
- rd_busy[k] = busy[rd_addr[k]], masked to 0 by bypass as above.
- Width rules:
  - Addresses are full AW bits; no out-of-range address exists (NREG is a power of two).
  - No X on any output for any input combination after reset.
- Reset mid-operation: an asynchronous clear during an active write or issue discards both; that edge has no effect.

Decomposition:
- Shared package regfile_pkg holds:
  - default DW and NREG constants;
  - the ZERO_IDX constant (0);
  - a helper function for packed-port slice offsets.
- One natural sub-module: rf_read_port, which performs address mux, zero masking, bypass compare and busy lookup.
  - Instantiated NUM_RD times in a generate loop.
- Storage and scoreboard stay in the top module.

Test Plan:
1. Reset clears everything: write 0xFFFF0000 to r3, pulse clear_neg low mid-cycle -> rd_data for r3 = 0 immediately, busy_vec = 0, without waiting for a clk edge.
2. Basic write and read: write r3=0xFFFF0000 then r2=0xFFFFFFFF, set rd_addr={r3,r2} -> ports return 0xFFFFFFFF and 0xFFFF0000 one cycle after each write; a write to r0 of 0x12345678 -> r0 reads 0.
3. Bypass on and off: in the same cycle as the write r5=0xA5A5A5A5, read r5 -> BYPASS=1 gives 0xA5A5A5A5 that cycle; BYPASS=0 gives the old value (0) that cycle and 0xA5A5A5A5 the next.
4. Scoreboard set and clear: issue r7 -> busy_vec[7]=1 next cycle and rd_busy=1 on a port reading r7; write r7=0x11 -> busy cleared; with BYPASS=1, rd_busy drops to 0 in the write cycle itself.
5. Simultaneous issue and write on r9 -> r9=data written and busy[9]=1 after the edge; issue to r0 -> busy_vec stays 0.
6. Parametric run with DW=16, NREG=8, NUM_RD=4:
   - sweep all addresses on all four ports against a reference array model;
   - use random wr_en and issue_en for 2000 cycles;
   - require zero data or busy mismatches.
